// File: rtl/profiler_frame_scheduler.sv
// profiler_frame_scheduler
//   Collects a snapshot of all profiler counter words on a periodic interval
//   tick or a host request and streams it out as one frame on a 32-bit
//   valid/ready link: header {MAGIC, frame_seq}, NUM_WORDS data words, then an
//   XOR checksum word flagged with out_last. Triggers that arrive while a frame
//   is in flight are counted in dropped_count and otherwise ignored.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   enable          runs the interval timer and gates all triggers
//   counters_flat   NUM_WORDS counter words, word k at [32*k +: 32]
//   host_req        one-cycle manual snapshot request
//   out_data/out_valid/out_ready/out_last   frame stream toward the host link
//   busy            high whenever a frame is being captured or sent
//   frame_seq       sequence number the next frame header will carry
//   dropped_count   saturating count of triggers lost while busy
module profiler_frame_scheduler #(
  parameter int unsigned NUM_WORDS       = 8,
  parameter int unsigned INTERVAL_CYCLES = 1000000,
  parameter logic [15:0] MAGIC           = 16'hABAC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_WORDS*32-1:0] counters_flat,
  input  logic                   host_req,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic [15:0]            frame_seq,
  output logic [15:0]            dropped_count
);

  localparam int unsigned CNT_W = $clog2(INTERVAL_CYCLES);
  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_HDR,
    S_DATA,
    S_CSUM
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] interval_cnt;
  logic             tick;
  logic             trigger;
  logic             xfer;
  logic [IDX_W-1:0] idx;
  logic [31:0]      acc;
  logic [31:0]      header;
  logic [31:0]      shadow [NUM_WORDS];

  assign tick    = enable && (interval_cnt == CNT_LAST);
  assign trigger = enable && (tick || host_req);
  assign xfer    = out_valid && out_ready;
  assign header  = {MAGIC, frame_seq};
  assign busy    = (state != S_IDLE);

  // Interval timer: free-runs while enabled, parked at zero otherwise.
  // NOTE: sequential state is always assigned with <= so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      interval_cnt <= '0;
    end else if (!enable || tick) begin
      interval_cnt <= '0;
    end else begin
      interval_cnt <= interval_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (trigger) state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_HDR;
      S_HDR:     if (xfer) state_next = S_DATA;
      S_DATA:    if (xfer && (idx == IDX_LAST)) state_next = S_CSUM;
      S_CSUM:    if (xfer) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Frame datapath. out_data/out_last are loaded one state ahead so the stream
  // is driven purely from registers and only changes on a handshake.
  // NOTE: the shadow bank is explicitly cleared on reset because its contents
  // are observable on the stream; it is small enough to live in flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_WORDS; k++) shadow[k] <= '0;
      acc       <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_seq <= '0;
    end else begin
      case (state)
        S_CAPTURE: begin
          for (int k = 0; k < NUM_WORDS; k++) shadow[k] <= counters_flat[32*k +: 32];
          acc       <= header;
          out_data  <= header;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
        end
        S_HDR: begin
          if (xfer) begin
            out_data <= shadow[0];
            idx      <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            acc <= acc ^ out_data;
            if (idx == IDX_LAST) begin
              // Checksum folds in the word being handed over this cycle.
              out_data <= acc ^ out_data;
              out_last <= 1'b1;
            end else begin
              out_data <= shadow[idx + 1'b1];
              idx      <= idx + 1'b1;
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_seq <= frame_seq + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Overrun accounting; the CSUM handshake cycle still counts as busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropped_count <= '0;
    end else if (trigger && busy && (dropped_count != 16'hFFFF)) begin
      dropped_count <= dropped_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_profiler_frame_scheduler.sv
// Bench for profiler_frame_scheduler (NUM_WORDS=4, INTERVAL_CYCLES=10).
// A frame-level model predicts, per cycle, whether a frame is in flight, the
// list of words still to be sent, the sequence number and the drop count.
module tb_profiler_frame_scheduler;

  localparam int          NW    = 4;
  localparam int          INTV  = 10;
  localparam logic [15:0] MAGIC = 16'hABAC;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [NW*32-1:0]  counters_flat;
  logic              host_req;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic [15:0]       frame_seq;
  logic [15:0]       dropped_count;

  profiler_frame_scheduler #(
    .NUM_WORDS      (NW),
    .INTERVAL_CYCLES(INTV),
    .MAGIC          (MAGIC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .counters_flat(counters_flat),
    .host_req     (host_req),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .frame_seq    (frame_seq),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model state.
  logic [31:0] exp_q[$];
  bit          m_busy;
  bit          m_cap;
  logic [15:0] m_seq;
  logic [15:0] m_drop;
  int          m_cnt;
  int          frames_done;

  // Evaluated at the falling edge, i.e. for the cycle that ends at the next
  // rising edge: compare, then advance the model by one cycle.
  task automatic scoreboard();
    bit          t_tick, t_trig, t_hs, t_was_busy;
    logic [31:0] x, w;
    if (rst) begin
      exp_q.delete();
      m_busy = 0; m_cap = 0; m_seq = '0; m_drop = '0; m_cnt = 0;
      return;
    end
    n_checks++;
    if (busy !== m_busy) begin
      n_fail++; $display("FAIL sb_busy: got %b want %b at %0t", busy, m_busy, $time);
    end
    n_checks++;
    if (out_valid !== (m_busy && !m_cap)) begin
      n_fail++; $display("FAIL sb_valid: got %b want %b at %0t", out_valid, m_busy && !m_cap, $time);
    end
    if (m_busy && !m_cap) begin
      n_checks++;
      if (out_data !== exp_q[0]) begin
        n_fail++; $display("FAIL sb_data: got %h want %h at %0t", out_data, exp_q[0], $time);
      end
      n_checks++;
      if (out_last !== (exp_q.size() == 1)) begin
        n_fail++; $display("FAIL sb_last: got %b want %b at %0t", out_last, exp_q.size() == 1, $time);
      end
    end
    n_checks++;
    if (frame_seq !== m_seq) begin
      n_fail++; $display("FAIL sb_seq: got %h want %h at %0t", frame_seq, m_seq, $time);
    end
    n_checks++;
    if (dropped_count !== m_drop) begin
      n_fail++; $display("FAIL sb_dropped: got %h want %h at %0t", dropped_count, m_drop, $time);
    end

    t_tick     = enable && (m_cnt == INTV - 1);
    t_trig     = enable && (t_tick || host_req);
    t_was_busy = m_busy;
    t_hs       = m_busy && !m_cap && out_ready;
    if (m_cap) begin
      x = {MAGIC, m_seq};
      exp_q.push_back(x);
      for (int k = 0; k < NW; k++) begin
        w = counters_flat[32*k +: 32];
        exp_q.push_back(w);
        x = x ^ w;
      end
      exp_q.push_back(x);
      m_cap = 0;
    end else if (t_hs) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        m_busy = 0;
        m_seq  = m_seq + 16'd1;
        frames_done++;
      end
    end
    if (t_trig) begin
      if (t_was_busy) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end else begin
        m_busy = 1; m_cap = 1;
      end
    end
    m_cnt = enable ? (t_tick ? 0 : m_cnt + 1) : 0;
  endtask

  // One clock cycle: model at the falling edge, then land 1 time unit after
  // the next rising edge where inputs are driven and outputs sampled.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      scoreboard();
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench in "cycle 0", the first cycle after reset release.
  task automatic do_reset(input logic en);
    rst = 1'b1; host_req = 1'b0; out_ready = 1'b1; enable = en;
    step(2);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int guard = 0;
    while (busy && guard < budget) begin step(); guard++; end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s: timeout, busy=%b after %0d cycles", name, busy, guard);
    end
  endtask

  task automatic test_reset();
    enable = 1'b0; host_req = 1'b0; out_ready = 1'b0; counters_flat = '1;
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_data, out_valid, out_last, busy, frame_seq, dropped_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%h v=%b l=%b busy=%b seq=%h drop=%h want all 0",
               out_data, out_valid, out_last, busy, frame_seq, dropped_count);
    end
    step(2);
  endtask

  task automatic test_single_frame();
    logic [31:0] exp6 [6];
    exp6 = '{32'hABAC0000, 32'd1, 32'd2, 32'd3, 32'd4, 32'hABAC0004};
    counters_flat = {32'd4, 32'd3, 32'd2, 32'd1};
    do_reset(1'b1);
    step();                       // cycle 1
    host_req = 1'b1;
    step();                       // cycle 2: CAPTURE
    host_req = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_capture_valid: got %b want 0", out_valid);
    end
    step();                       // cycle 3: header
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp6[i] || out_last !== (i == 5)) begin
        n_fail++;
        $display("FAIL single_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, out_valid, out_data, out_last, exp6[i], i == 5);
      end
      step();
    end
    n_checks++;
    if (frame_seq !== 16'd1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_after: got seq=%h busy=%b want seq=0001 busy=0", frame_seq, busy);
    end
  endtask

  task automatic test_interval();
    int   rises[$];
    logic prev_v = 1'b0;
    counters_flat = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_reset(1'b1);
    for (int c = 1; c <= 40; c++) begin
      step();
      if (out_valid && !prev_v) rises.push_back(c);
      prev_v = out_valid;
    end
    n_checks++;
    if (rises.size() != 3) begin
      n_fail++; $display("FAIL interval_frames: got %0d frame starts want 3", rises.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rises[i] != 11 + 10 * i) begin
          n_fail++; $display("FAIL interval_start%0d: got cycle %0d want %0d", i, rises[i], 11 + 10 * i);
        end
      end
    end
    n_checks++;
    if (frame_seq !== 16'd3 || dropped_count !== 16'd0) begin
      n_fail++; $display("FAIL interval_counts: got seq=%h drop=%h want 0003/0000", frame_seq, dropped_count);
    end
  endtask

  task automatic test_stall();
    logic [3:0]  pat = 4'b1001;
    logic        prev_v = 1'b0, prev_r = 1'b1, prev_l = 1'b0;
    logic [31:0] prev_d = '0;
    int          stalls = 0;
    int          base;
    counters_flat = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_reset(1'b1);
    base = frames_done;
    step();
    host_req = 1'b1;
    for (int c = 2; c <= 60; c++) begin
      step();
      host_req = 1'b0;
      if (prev_v && !prev_r) begin
        stalls++;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   out_valid, out_data, out_last, prev_d, prev_l);
        end
      end
      prev_v = out_valid; prev_d = out_data; prev_l = out_last;
      out_ready = pat[c % 4];
      prev_r = out_ready;
      counters_flat = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    out_ready = 1'b1;
    wait_idle("stall_drain", 40);
    n_checks++;
    if (stalls == 0 || frames_done <= base) begin
      n_fail++; $display("FAIL stall_activity: got stalls=%0d frames=%0d want >0", stalls, frames_done - base);
    end
  endtask

  task automatic test_overrun();
    int guard = 0;
    counters_flat = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_reset(1'b1);
    out_ready = 1'b0;
    step(60);
    n_checks++;
    if (dropped_count !== 16'd5 || out_valid !== 1'b1 || out_data !== {MAGIC, 16'h0000}) begin
      n_fail++;
      $display("FAIL overrun_five: got drop=%h v=%b d=%h want 0005 1 abac0000",
               dropped_count, out_valid, out_data);
    end
    host_req = 1'b1;
    while (dropped_count !== 16'hFFFE && guard < 70000) begin step(); guard++; end
    n_checks++;
    if (dropped_count !== 16'hFFFE) begin
      n_fail++; $display("FAIL overrun_reach: got %h want fffe within budget", dropped_count);
    end
    step(3);
    n_checks++;
    if (dropped_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL overrun_saturate: got %h want ffff", dropped_count);
    end
    host_req = 1'b0;
    out_ready = 1'b1;
    wait_idle("overrun_drain", 40);
  endtask

  task automatic test_reset_mid_frame();
    counters_flat = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
    do_reset(1'b1);
    step();                       // cycle 1
    host_req = 1'b1;
    step();
    host_req = 1'b0;
    step(12);                     // cycle 14: second frame (tick at 9), DATA idx=2
    n_checks++;
    if (frame_seq !== 16'd1 || out_valid !== 1'b1 || out_data !== 32'hC3) begin
      n_fail++; $display("FAIL midrst_pre: got seq=%h v=%b d=%h want 0001 1 000000c3", frame_seq, out_valid, out_data);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || frame_seq !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%b l=%b busy=%b seq=%h want 0 0 0 0000", out_valid, out_last, busy, frame_seq);
    end
    step();
    #1 rst = 1'b0;
    step();
    host_req = 1'b1;
    step();
    host_req = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hABAC0000) begin
      n_fail++; $display("FAIL midrst_restart: got v=%b d=%h want 1 abac0000", out_valid, out_data);
    end
    wait_idle("midrst_drain", 40);
  endtask

  task automatic test_wrap_disable();
    int extra = 0;
    counters_flat = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_reset(1'b1);
    step();                       // cycle 1, IDLE
    force dut.frame_seq = 16'hFFFF;
    m_seq = 16'hFFFF;
    step();                       // cycle 2
    release dut.frame_seq;
    host_req = 1'b1;
    step();                       // cycle 3: CAPTURE
    host_req = 1'b0;
    step();                       // cycle 4: header
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hABACFFFF) begin
      n_fail++; $display("FAIL wrap_header: got v=%b d=%h want 1 abacffff", out_valid, out_data);
    end
    enable = 1'b0;
    step(6);                      // cycle 10, frame finished at end of cycle 9
    n_checks++;
    if (frame_seq !== 16'h0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL wrap_seq: got seq=%h busy=%b want 0000 0", frame_seq, busy);
    end
    for (int c = 0; c < 30; c++) begin
      host_req = (c == 7);
      step();
      if (out_valid !== 1'b0 || busy !== 1'b0) extra++;
    end
    host_req = 1'b0;
    n_checks++;
    if (extra != 0) begin
      n_fail++; $display("FAIL disabled_quiet: got %0d active cycles want 0", extra);
    end
    enable = 1'b1;                // timer restarts from 0 in this cycle
    step(10);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reenable_early: got valid %b want 0", out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hABAC0000) begin
      n_fail++; $display("FAIL reenable_first: got v=%b d=%h want 1 abac0000", out_valid, out_data);
    end
    wait_idle("wrap_drain", 40);
  endtask

  task automatic test_random();
    int base;
    do_reset(1'b1);
    base = frames_done;
    for (int c = 0; c < 3000; c++) begin
      out_ready     = ($urandom_range(0, 3) != 0);
      host_req      = ($urandom_range(0, 15) == 0);
      enable        = ($urandom_range(0, 63) != 0);
      counters_flat = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    host_req = 1'b0; enable = 1'b0; out_ready = 1'b1;
    wait_idle("random_drain", 40);
    n_checks++;
    if (frames_done - base < 20) begin
      n_fail++; $display("FAIL random_frames: got %0d frames want >= 20", frames_done - base);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; host_req = 1'b0; out_ready = 1'b0; counters_flat = '0;
    frames_done = 0;
    test_reset();
    test_single_frame();
    test_interval();
    test_stall();
    test_overrun();
    test_reset_mid_frame();
    test_wrap_disable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
